// File: rtl/spi_reg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl_pkg
// Shared definitions for the SPI register controller: the register map,
// reset values, frame geometry, FSM state encoding and the read-data mux.
// ---------------------------------------------------------------------------
package spi_reg_ctrl_pkg;

   localparam int FRAME_BITS = 16;
   localparam int CNT_W      = 5;

   // Counter values at which the frame completes and read data is loaded
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] RD_BIT   = CNT_W'(8);

   localparam logic [6:0] ADDR_CTRL   = 7'h00;
   localparam logic [6:0] ADDR_PERIOD = 7'h01;
   localparam logic [6:0] ADDR_DUTY   = 7'h02;
   localparam logic [6:0] ADDR_STATUS = 7'h03;

   localparam logic       RST_EN     = 1'b0;
   localparam logic [7:0] RST_PERIOD = 8'hFF;
   localparam logic [7:0] RST_DUTY   = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Register read mux; unmapped addresses read back as zero
   function automatic logic [7:0] read_reg(input logic [6:0] addr,
                                           input logic       en,
                                           input logic [7:0] period,
                                           input logic [7:0] duty,
                                           input logic       sticky);
      logic [7:0] data;
      data = 8'h00;
      case (addr)
         ADDR_CTRL:   data = {7'b0, en};
         ADDR_PERIOD: data = period;
         ADDR_DUTY:   data = duty;
         ADDR_STATUS: data = {6'b0, sticky, en};
         default:     data = 8'h00;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl_if
// SPI mode-0 bus bundle.
//   sclk  : serial clock driven by the master
//   cs_n  : active-low chip select driven by the master
//   mosi  : master-out data, MSB first
//   miso  : slave-out data
// ---------------------------------------------------------------------------
interface spi_reg_ctrl_if;

   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs_n, output mosi, input miso);
   modport slave  (input sclk, input cs_n, input mosi, output miso);

endinterface

// File: rtl/spi_reg_ctrl_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Multi-flop synchronizer for an asynchronous pin followed by rising and
// falling edge detection against a one-flop delayed copy of the synced level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   rise, fall : one-clk pulses on synced edges
// ---------------------------------------------------------------------------
module sync_edge_det #(
   parameter int   STAGES   = 2,
   parameter logic IDLE_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   // Reset loads the idle level so no spurious edge appears out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {STAGES{IDLE_VAL}};
         prev <= IDLE_VAL;
      end else begin
         sync[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            sync[i] <= sync[i-1];
         end
         prev <= sync[STAGES-1];
      end
   end

   assign rise = sync[STAGES-1] & ~prev;
   assign fall = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
// SPI mode-0 slave exposing a small PWM register file.
// Frame: bit15 R/W (1=write), bits14:8 address, bits7:0 data, MSB first.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi: SPI inputs, asynchronous to clk
//   spi_miso          : registered read data during bits 8-15 of a read
//   pwm_en/period/duty: register outputs
//   cfg_update        : one-clk pulse on an accepted write
//   frame_err         : one-clk pulse when a frame is aborted early
// ---------------------------------------------------------------------------
module spi_reg_ctrl
   import spi_reg_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       pwm_en,
   output logic [7:0] pwm_period,
   output logic [7:0] pwm_duty,
   output logic       cfg_update,
   output logic       frame_err
);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic mosi_s;

   state_t state, state_next;
   logic [CNT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] shift_reg, shift_next;
   logic [6:0]            miso_sr;
   logic                  err_sticky;
   logic                  shift_en, start_en, clear_sticky;
   logic [7:0]            rd_data;

   sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs (
      .clk(clk), .rst_n(rst_n), .din(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi shares the sclk synchronizer depth so a synced sclk rise sees the
   // data bit that was stable at the pin when sclk rose
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_sync <= '0;
      end else begin
         mosi_sync[0] <= spi_mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            mosi_sync[i] <= mosi_sync[i-1];
         end
      end
   end

   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Read data is chosen from the address byte captured after eight bits;
   // write frames shift out zeros
   assign rd_data = shift_reg[7] ? 8'h00 :
                    read_reg(shift_reg[6:0], pwm_en, pwm_period, pwm_duty, err_sticky);

   // Next-state and pulse decode. A cs_n rise in SHIFT takes priority over
   // a coincident sclk rise, so a frame ending together with cs_n is aborted.
   always_comb begin
      state_next   = state;
      cfg_update   = 1'b0;
      frame_err    = 1'b0;
      shift_en     = 1'b0;
      start_en     = 1'b0;
      clear_sticky = 1'b0;
      shift_next   = {shift_reg[FRAME_BITS-2:0], mosi_s};
      case (state)
         ST_IDLE: begin
            if (cs_fall) begin
               state_next = ST_SHIFT;
               start_en   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_next = ST_IDLE;
               frame_err  = 1'b1;
            end else if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  if (shift_next[15]) begin
                     state_next = ST_COMMIT;
                  end else begin
                     state_next   = ST_DONE;
                     clear_sticky = (shift_next[14:8] == ADDR_STATUS);
                  end
               end
            end
         end
         ST_COMMIT: begin
            cfg_update = shift_reg[15] &&
                         (shift_reg[14:8] == ADDR_CTRL ||
                          shift_reg[14:8] == ADDR_PERIOD ||
                          shift_reg[14:8] == ADDR_DUTY);
            // A cs_n rise here would otherwise be missed by DONE
            state_next = cs_rise ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            if (cs_rise) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register, frame capture, register file and MISO shifter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         pwm_en     <= RST_EN;
         pwm_period <= RST_PERIOD;
         pwm_duty   <= RST_DUTY;
         err_sticky <= 1'b0;
         spi_miso   <= 1'b0;
         miso_sr    <= '0;
      end else begin
         state <= state_next;

         if (start_en) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
         end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= shift_next;
         end

         if (cfg_update) begin
            case (shift_reg[14:8])
               ADDR_CTRL:   pwm_en     <= shift_reg[0];
               ADDR_PERIOD: pwm_period <= shift_reg[7:0];
               ADDR_DUTY:   pwm_duty   <= shift_reg[7:0];
               default:     ;
            endcase
         end

         if (frame_err) begin
            err_sticky <= 1'b1;
         end else if (clear_sticky) begin
            err_sticky <= 1'b0;
         end

         // MISO is only live while the frame is still shifting
         if (state_next != ST_SHIFT) begin
            spi_miso <= 1'b0;
            miso_sr  <= '0;
         end else if (sclk_fall && bit_cnt == RD_BIT) begin
            spi_miso <= rd_data[7];
            miso_sr  <= rd_data[6:0];
         end else if (sclk_fall && bit_cnt > RD_BIT) begin
            spi_miso <= miso_sr[6];
            miso_sr  <= {miso_sr[5:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_ctrl
// Directed and randomized SPI frames against a register-level reference
// model of the PWM register file.
// ---------------------------------------------------------------------------
module tb_spi_reg_ctrl;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pwm_en;
   logic [7:0] pwm_period;
   logic [7:0] pwm_duty;
   logic       cfg_update;
   logic       frame_err;

   int checks = 0;
   int failures = 0;
   int cfg_cnt = 0;
   int err_cnt = 0;

   // Reference model state
   logic       m_en;
   logic [7:0] m_period;
   logic [7:0] m_duty;
   logic       m_sticky;

   spi_reg_ctrl_if bus();

   spi_reg_ctrl #(.SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .spi_sclk(bus.sclk),
      .spi_cs_n(bus.cs_n),
      .spi_mosi(bus.mosi),
      .spi_miso(bus.miso),
      .pwm_en(pwm_en),
      .pwm_period(pwm_period),
      .pwm_duty(pwm_duty),
      .cfg_update(cfg_update),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge
   always @(negedge clk) begin
      if (cfg_update === 1'b1) cfg_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en     = 1'b0;
      m_period = 8'hFF;
      m_duty   = 8'h00;
      m_sticky = 1'b0;
   endtask

   // Register-level effect of one frame; returns expected read byte and pulses
   task automatic model_frame(input logic [15:0] f, input int nbits, input bit race,
                              output logic [7:0] rd, output int cfg, output int err);
      logic [6:0] a;
      a   = f[14:8];
      rd  = 8'h00;
      cfg = 0;
      err = 0;
      if (nbits < 16 || race) begin
         err      = 1;
         m_sticky = 1'b1;
      end else if (f[15]) begin
         if (a == 7'd0) begin m_en = f[0];       cfg = 1; end
         if (a == 7'd1) begin m_period = f[7:0]; cfg = 1; end
         if (a == 7'd2) begin m_duty = f[7:0];   cfg = 1; end
      end else begin
         if (a == 7'd0) rd = {7'b0, m_en};
         if (a == 7'd1) rd = m_period;
         if (a == 7'd2) rd = m_duty;
         if (a == 7'd3) begin
            rd       = {6'b0, m_sticky, m_en};
            m_sticky = 1'b0;
         end
      end
   endtask

   // Bit-bangs one mode-0 frame; nbits beyond 16 sends random filler bits.
   // With race set, cs_n rises together with the last sclk rise.
   task automatic applyStimulus(input logic [15:0] frame, input int nbits, input bit race,
                                output logic [7:0] rd, output logic low_ok,
                                output int cfg_d, output int err_d);
      int c0, e0;
      c0     = cfg_cnt;
      e0     = err_cnt;
      rd     = 8'h00;
      low_ok = 1'b1;
      bus.cs_n = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < nbits; i++) begin
         if (i < 16) bus.mosi = frame[15-i];
         else        bus.mosi = 1'($urandom_range(0, 1));
         wait_clk(HALF);
         if (i < 8) begin
            if (bus.miso !== 1'b0) low_ok = 1'b0;
         end else if (i < 16) begin
            rd[15-i] = bus.miso;
         end
         bus.sclk = 1'b1;
         if (race && i == nbits - 1) bus.cs_n = 1'b1;
         wait_clk(HALF);
         bus.sclk = 1'b0;
      end
      wait_clk(HALF);
      bus.cs_n = 1'b1;
      wait_clk(3 * HALF);
      cfg_d = cfg_cnt - c0;
      err_d = err_cnt - e0;
   endtask

   task automatic doFrame(input string tag, input logic [15:0] f, input int nbits, input bit race);
      logic [7:0] exp_rd, got_rd;
      int exp_cfg, exp_err, got_cfg, got_err;
      logic low_ok;
      model_frame(f, nbits, race, exp_rd, exp_cfg, exp_err);
      applyStimulus(f, nbits, race, got_rd, low_ok, got_cfg, got_err);
      if (!f[15] && nbits >= 16 && !race)
         checkOutput($sformatf("%s.rd", tag), {8'h0, got_rd}, {8'h0, exp_rd});
      checkOutput($sformatf("%s.cfg_pulses", tag), 16'(got_cfg), 16'(exp_cfg));
      checkOutput($sformatf("%s.err_pulses", tag), 16'(got_err), 16'(exp_err));
      checkOutput($sformatf("%s.miso_low07", tag), {15'h0, low_ok}, 16'h1);
      checkOutput($sformatf("%s.miso_idle", tag), {15'h0, bus.miso}, 16'h0);
      checkOutput($sformatf("%s.regs", tag), {pwm_en, 7'h0, pwm_period}, {m_en, 7'h0, m_period});
      checkOutput($sformatf("%s.duty", tag), {8'h0, pwm_duty}, {8'h0, m_duty});
   endtask

   task automatic check_reset_outputs(input string tag);
      checkOutput($sformatf("%s.en", tag), {15'h0, pwm_en}, 16'h0);
      checkOutput($sformatf("%s.period", tag), {8'h0, pwm_period}, 16'h00FF);
      checkOutput($sformatf("%s.duty", tag), {8'h0, pwm_duty}, 16'h0000);
      checkOutput($sformatf("%s.pulses", tag), {14'h0, cfg_update, frame_err}, 16'h0);
      checkOutput($sformatf("%s.miso", tag), {15'h0, bus.miso}, 16'h0);
   endtask

   initial begin
      logic [15:0] f;
      logic [15:0] partial;
      int nb, c0, e0;
      bit race;

      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      model_reset();
      rst_n = 1'b0;
      wait_clk(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      wait_clk(4);
      $display("[TB] directed frames");

      doFrame("w_period", 16'h8132, 16, 1'b0);
      doFrame("w_duty",   16'h8240, 16, 1'b0);
      doFrame("r_duty",   16'h0200, 16, 1'b0);
      doFrame("abort9",   16'h8001, 9,  1'b0);
      doFrame("r_status", 16'h0300, 16, 1'b0);
      doFrame("r_status2",16'h0300, 16, 1'b0);
      doFrame("w_bad",    16'h8555, 16, 1'b0);
      doFrame("w_status", 16'h83FF, 16, 1'b0);
      doFrame("r_bad",    16'h0500, 16, 1'b0);
      doFrame("w_ctrl20", 16'h8001, 20, 1'b0);
      doFrame("r_ctrl",   16'h0000, 16, 1'b0);
      doFrame("race16",   16'h8277, 16, 1'b1);
      doFrame("r_status3",16'h0300, 16, 1'b0);

      // Reset pulsed in the middle of a frame
      c0 = cfg_cnt;
      e0 = err_cnt;
      partial = 16'h8233;
      bus.cs_n = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < 10; i++) begin
         bus.mosi = partial[15-i];
         wait_clk(HALF);
         bus.sclk = 1'b1;
         wait_clk(HALF);
         bus.sclk = 1'b0;
      end
      wait_clk(2);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      model_reset();
      bus.cs_n = 1'b1;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(4);
      checkOutput("mid_rst.no_pulses", 16'(cfg_cnt - c0 + err_cnt - e0), 16'h0);
      doFrame("w_duty_post", 16'h8210, 16, 1'b0);

      $display("[TB] random frames");
      for (int n = 0; n < 30; n++) begin
         int r;
         r = int'($urandom_range(0, 7));
         f[15]   = 1'($urandom_range(0, 1));
         f[14:8] = (r < 5) ? 7'(r) : 7'($urandom_range(0, 127));
         f[7:0]  = 8'($urandom_range(0, 255));
         nb   = 16;
         race = 1'b0;
         r = int'($urandom_range(0, 9));
         if (r == 0)      nb = int'($urandom_range(1, 15));
         else if (r == 1) nb = int'($urandom_range(17, 19));
         else if (r == 2) race = 1'b1;
         doFrame($sformatf("rnd%0d", n), f, nb, race);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
